gpr_file: RTL and testbench

- General-purpose register file and responder to the decode stage's operand-fetch interface.
- Decode drives two read addresses (rs, rt) and receives both operands combinationally in the same cycle. The write-back stage writes one result per cycle.
- Storage has no per-entry reset, so a post-reset clear sequencer zeroes it. An internal write-through bypass lets decode see a same-cycle write-back result.

---
 rtl/gpr_file.sv | 139 +++++++++++++
 tb/tb_gpr_file.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/gpr_file.sv
// General-purpose register file with two combinational read ports, one write
// port with same-cycle write-through bypass, and a post-reset clear sequencer
// that zeroes the storage (which itself carries no per-entry reset).
module gpr_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] data_rs,
    output logic [DATA_WIDTH-1:0] data_rt,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ready,
    output logic                  clearing
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic [ADDR_WIDTH-1:0]   w_clr_ptr_nxt;
    logic                    r_ready;
    logic                    w_ready_nxt;
    logic                    r_clearing;
    logic                    w_clearing_nxt;

    logic [DATA_WIDTH-1:0]   r_mem [NUM_REGS];
    logic                    w_mem_we;
    logic [IDX_W-1:0]        w_mem_idx;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    logic                    w_wr_in_range;
    logic                    w_rs_in_range;
    logic                    w_rt_in_range;
    logic                    w_run;

    // Full-width range checks so out-of-range addresses never alias onto a register
    assign w_wr_in_range = (wr_addr <= LAST_REG);
    assign w_rs_in_range = (rs <= LAST_REG);
    assign w_rt_in_range = (rt <= LAST_REG);
    assign w_run         = (r_state == ST_RUN);

    // Next-state, clear pointer, status flags and storage write port selection
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_ptr_nxt  = r_clr_ptr;
        w_ready_nxt    = r_ready;
        w_clearing_nxt = r_clearing;
        w_mem_we       = 1'b0;
        w_mem_idx      = '0;
        w_mem_wdata    = '0;
        case (r_state)
            ST_CLEAR: begin
                // Sequencer owns the write port; write-back traffic is ignored
                w_mem_we      = 1'b1;
                w_mem_idx     = r_clr_ptr[IDX_W-1:0];
                w_mem_wdata   = '0;
                w_clr_ptr_nxt = r_clr_ptr + ADDR_WIDTH'(1);
                if (r_clr_ptr == LAST_REG) begin
                    w_state_nxt    = ST_RUN;
                    w_ready_nxt    = 1'b1;
                    w_clearing_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                if (wr_en && w_wr_in_range) begin
                    w_mem_we    = 1'b1;
                    w_mem_idx   = wr_addr[IDX_W-1:0];
                    w_mem_wdata = wr_data;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // State and status registers; reset restarts the clear sequence from entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_CLEAR;
            r_clr_ptr  <= '0;
            r_ready    <= 1'b0;
            r_clearing <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_ptr  <= w_clr_ptr_nxt;
            r_ready    <= w_ready_nxt;
            r_clearing <= w_clearing_nxt;
        end
    end

    // Storage array; contents untouched on a reset edge
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // Read port A with write-through bypass; zero while clearing or out of range
    always_comb begin
        data_rs = '0;
        if (w_run && w_rs_in_range) begin
            if (wr_en && (wr_addr == rs)) begin
                data_rs = wr_data;
            end else begin
                data_rs = r_mem[rs[IDX_W-1:0]];
            end
        end
    end

    // Read port B, same rules as port A
    always_comb begin
        data_rt = '0;
        if (w_run && w_rt_in_range) begin
            if (wr_en && (wr_addr == rt)) begin
                data_rt = wr_data;
            end else begin
                data_rt = r_mem[rt[IDX_W-1:0]];
            end
        end
    end

    assign ready    = r_ready;
    assign clearing = r_clearing;

endmodule

// File: tb/tb_gpr_file.sv
// Directed + short random bench for gpr_file using a reference model and a
// scoreboard queue of expected read/status values.
module tb_gpr_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] data_rs;
    logic [DW-1:0] data_rt;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          ready;
    logic          clearing;

    always #5 clk = ~clk;

    gpr_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs       (rs),
        .rt       (rt),
        .data_rs  (data_rs),
        .data_rt  (data_rt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ready    (ready),
        .clearing (clearing)
    );

    typedef struct packed {
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
        logic          rdy;
        logic          clr;
    } exp_t;

    exp_t          sb_q[$];
    string         tag_q[$];

    // Reference model of the register file
    logic [DW-1:0] mm [NR];
    logic          m_run;
    int unsigned   m_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] mread(input logic [AW-1:0] a, input logic we,
                                            input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic [3:0] idx;
        if (!m_run) return '0;
        if (32'(a) >= NR) return '0;
        if (we && (wa == a)) return wd;
        idx = a[3:0];
        return mm[idx];
    endfunction

    // One cycle: drive just after a rising edge, check at the falling edge,
    // then advance the model across the next rising edge.
    task automatic step(input logic r, input logic [AW-1:0] a_rs, input logic [AW-1:0] a_rt,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input string tag);
        exp_t  e;
        exp_t  got;
        string t;
        logic [3:0] idx;
        rst     = r;
        rs      = a_rs;
        rt      = a_rt;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        e.rs  = mread(a_rs, we, wa, wd);
        e.rt  = mread(a_rt, we, wa, wd);
        e.rdy = m_run;
        e.clr = !m_run;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        got = sb_q.pop_front();
        t   = tag_q.pop_front();
        chk({t, ".data_rs"},  data_rs,       got.rs);
        chk({t, ".data_rt"},  data_rt,       got.rt);
        chk({t, ".ready"},    DW'(ready),    DW'(got.rdy));
        chk({t, ".clearing"}, DW'(clearing), DW'(got.clr));
        @(posedge clk);
        if (r) begin
            m_run = 1'b0;
            m_cnt = 0;
        end else if (!m_run) begin
            mm[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == NR) m_run = 1'b1;
        end else if (we && (32'(wa) < NR)) begin
            idx = wa[3:0];
            mm[idx] = wd;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(NR); i++) mm[i] = 'x;
        m_run   = 1'b0;
        m_cnt   = 0;
        rst     = 1'b1;
        rs      = '0;
        rt      = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // Clear sequence: ready must rise exactly after 16 edges with rst low
        for (int i = 0; i < 16; i++)
            step(1'b0, AW'(i), AW'(i), 1'b1, AW'(i), 32'hFFFF_0000, $sformatf("clr%0d", i));
        for (int i = 0; i < 8; i++)
            step(1'b0, AW'(2 * i), AW'(2 * i + 1), 1'b0, '0, '0, $sformatf("zero%0d", i));

        // Write then read on both ports
        step(1'b0, '0, '0, 1'b1, AW'(3), 32'hDEAD_BEEF, "wr_r3");
        step(1'b0, AW'(3), AW'(3), 1'b0, '0, '0, "rd_r3");

        // Bypass on port A while port B reads a different register
        step(1'b0, '0, '0, 1'b1, AW'(8), 32'h0000_0088, "wr_r8");
        step(1'b0, AW'(7), AW'(8), 1'b1, AW'(7), 32'h1234_5678, "byp_r7");
        step(1'b0, AW'(7), AW'(8), 1'b0, '0, '0, "rd_r7");

        // Out-of-range write/read: no aliasing onto r4
        step(1'b0, '0, '0, 1'b1, AW'(4), 32'h0000_0044, "wr_r4");
        step(1'b0, AW'(20), AW'(4), 1'b1, AW'(20), 32'hFFFF_FFFF, "oor_byp");
        step(1'b0, AW'(20), AW'(4), 1'b0, '0, '0, "oor_rd");
        step(1'b0, AW'(31), AW'(16), 1'b0, '0, '0, "oor_hi");

        // Reset mid-clear restarts the sequence; writes while clearing are dropped
        step(1'b0, '0, '0, 1'b1, AW'(5), 32'h0000_AAAA, "wr_r5");
        step(1'b0, AW'(5), '0, 1'b0, '0, '0, "rd_r5");
        step(1'b1, '0, '0, 1'b0, '0, '0, "rst_a");
        for (int i = 0; i < 8; i++)
            step(1'b0, AW'(2), AW'(5), 1'b1, AW'(2), 32'h0000_0055, $sformatf("clrA%0d", i));
        step(1'b1, '0, '0, 1'b0, '0, '0, "rst_b");
        for (int i = 0; i < 16; i++)
            step(1'b0, AW'(2), AW'(5), 1'b1, AW'(2), 32'h0000_0055, $sformatf("clrB%0d", i));
        step(1'b0, AW'(5), AW'(2), 1'b0, '0, '0, "post_clr");

        // Back-to-back writes to r1, each visible the same cycle
        for (int i = 1; i <= 3; i++)
            step(1'b0, AW'(1), AW'(1), 1'b1, AW'(1), DW'(i), $sformatf("b2b%0d", i));
        step(1'b0, AW'(1), '0, 1'b0, '0, '0, "b2b_hold");

        // Random traffic including out-of-range addresses
        for (int i = 0; i < 60; i++)
            step(1'b0, AW'($urandom_range(0, 19)), AW'($urandom_range(0, 19)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 19)), $urandom,
                 $sformatf("rnd%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
